// File: rtl/uart_rx_engine.sv
// uart_rx_engine: oversampling UART receiver with 2-of-3 majority sampling,
// parity/stop checking and a parallel output word with one-cycle status pulses.
module uart_rx_engine #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_in,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  par_en,
   input  logic                  par_type,
   input  logic                  stop2,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stop_err,
   output logic                  busy
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t state, state_nx;
   logic s1, rxs;
   logic [PRESCALE_W-1:0] p, edge_cnt, half;
   logic [3:0] bit_cnt;
   logic [1:0] smp;
   logic [DATA_WIDTH-1:0] sh;
   logic pen, ptype, st2, stop_idx, pend_par, pend_stop;
   logic wrap, decide, maj, last_bit, start, fin, ok;

   assign half = p >> 1;
   assign wrap = edge_cnt == p - PRESCALE_W'(1);
   assign decide = edge_cnt == half + PRESCALE_W'(1);
   assign maj = (smp[0] & smp[1]) | (rxs & (smp[0] | smp[1]));
   assign last_bit = bit_cnt == 4'(DATA_WIDTH - 1);
   assign start = state == IDLE && !rxs;
   assign fin = state == STOP && state_nx == IDLE;
   assign ok = !pend_par && !pend_stop && maj;
   assign busy = state != IDLE;

   always_ff @(posedge clk or negedge rst)
      if (!rst) {rxs, s1} <= 2'b11;
      else {rxs, s1} <= {s1, rx_in};

   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= IDLE;
      else state <= state_nx;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (!rxs) state_nx = START;
         START:   if (decide && maj) state_nx = IDLE;
                  else if (wrap) state_nx = DATA;
         DATA:    if (wrap && last_bit) state_nx = pen ? PARITY : STOP;
         PARITY:  if (wrap) state_nx = STOP;
         STOP:    if (decide && (!st2 || stop_idx)) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // The frame closes at the final stop-bit decision, so results land half a bit early.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p <= '0;
         pen <= 1'b0;
         ptype <= 1'b0;
         st2 <= 1'b0;
         edge_cnt <= '0;
         bit_cnt <= '0;
         smp <= '0;
         sh <= '0;
         stop_idx <= 1'b0;
         pend_par <= 1'b0;
         pend_stop <= 1'b0;
         rx_data <= '0;
         data_valid <= 1'b0;
         par_err <= 1'b0;
         stop_err <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         par_err <= 1'b0;
         stop_err <= 1'b0;
         edge_cnt <= (state == IDLE || state_nx == IDLE || wrap) ? '0 : edge_cnt + PRESCALE_W'(1);
         if (edge_cnt == half - PRESCALE_W'(1)) smp[0] <= rxs;
         if (edge_cnt == half) smp[1] <= rxs;
         if (start) begin
            p <= (prescale < PRESCALE_W'(6)) ? PRESCALE_W'(6) : prescale;
            pen <= par_en;
            ptype <= par_type;
            st2 <= stop2;
            bit_cnt <= '0;
            stop_idx <= 1'b0;
            pend_par <= 1'b0;
            pend_stop <= 1'b0;
         end
         if (state == DATA && decide) sh <= {maj, sh[DATA_WIDTH-1:1]};
         if (state == DATA && wrap) bit_cnt <= last_bit ? '0 : bit_cnt + 4'd1;
         if (state == PARITY && decide && maj != (^sh ^ ptype)) pend_par <= 1'b1;
         if (state == STOP && decide && !maj) pend_stop <= 1'b1;
         if (state == STOP && wrap) stop_idx <= 1'b1;
         if (fin) begin
            data_valid <= ok;
            par_err <= pend_par;
            stop_err <= pend_stop || !maj;
            if (ok) rx_data <= sh;
         end
      end
   end
endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
Parametrised UART receiver engine. It combines the frame state machine with an integrated oversampling edge counter, a bit counter, majority-vote sampling, a parity/stop checker and an output deserializer. It takes the raw serial line and delivers a parallel word with a one-cycle valid pulse. Data width, oversampling ratio, parity mode and stop-bit count are configurable, so one instance serves every UART channel in the design.

Parameters:
DATA_WIDTH, 8, payload bits per frame (5..9 supported)
PRESCALE_W, 6, width of prescale input; max oversampling ratio is 2^PRESCALE_W-1

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
rx_in  input  1  raw serial line, idle high, asynchronous to clk
prescale  input  PRESCALE_W  clocks per bit; values below 6 are treated as 6
par_en  input  1  1 = parity bit present after data
par_type  input  1  0 = even, 1 = odd
stop2  input  1  0 = one stop bit, 1 = two stop bits
rx_data  output  DATA_WIDTH  last good word, LSB first on the line
data_valid  output  1  one-cycle pulse, rx_data is new
par_err  output  1  one-cycle pulse, parity mismatch in finished frame
stop_err  output  1  one-cycle pulse, a stop bit sampled 0
busy  output  1  high while state != IDLE

Behaviour:
- Reset: all outputs 0, except rx_data, which resets to all 0. Synchroniser flops reset to 1. State is IDLE. All counters are 0.
- rx_in passes through a 2-flop synchroniser. All logic below uses the synchronised value, rxs.
- Configuration latch: prescale, par_en, par_type and stop2 are captured on IDLE->START. Changes mid-frame are ignored until the next frame.
- Edge counter: counts 0..P-1 per bit, where P is the latched prescale. It wraps to 0 at P-1 and advances the bit.
- Sampling: three samples at edge_cnt = P/2-1, P/2 and P/2+1 (integer divide). The bit value is the 2-of-3 majority, decided at P/2+1.
- States:
  - IDLE: rxs==0 -> START, edge_cnt cleared to 0.
  - START: at the decision point, majority 1 -> glitch, go to IDLE with no flags. Majority 0 -> continue; at P-1 go to DATA.
  - DATA: majority bit shifts in LSB-first. bit_cnt counts 0..DATA_WIDTH-1. At P-1 of the last bit -> PARITY if par_en, else STOP.
  - PARITY: expected bit = XOR(data) XOR par_type. A mismatch records a pending par_err. At P-1 -> STOP.
  - STOP: majority 0 records a pending stop_err. With stop2=1, the first stop bit runs to P-1, then a second stop bit is sampled the same way. At the decision point of the final stop bit -> IDLE. The frame ends there, half a bit early, to tolerate baud mismatch and allow back-to-back frames.
- Frame end (cycle after the final stop decision):
  - No pending error: data_valid=1 and rx_data loads the shift register.
  - Otherwise: par_err and/or stop_err pulse, data_valid stays 0 and rx_data holds its previous value.
  - Both errors may pulse together.
- After frame end, a falling edge on rxs in IDLE starts the next frame immediately. There are no dead cycles beyond the synchroniser.
- Reset asserted mid-frame: the frame is aborted at once and no flags are issued. The first frame after reset release needs a full start bit.
- Shift-register bits not yet received are never visible on rx_data.
- busy is high from the cycle the FSM leaves IDLE until the cycle it returns.

Test Plan:
1. P=8, par_en=0, stop2=0; send 0xA5 -> single data_valid pulse with rx_data=0xA5. par_err=stop_err=0. busy high for ~9.5 bit times.
2. P=8, par_en=1, par_type=0; send 0x37 with parity 1 -> valid with rx_data=0x37. Then send 0x37 with parity 0 -> par_err pulse, no valid, rx_data stays 0x37.
3. P=16; send 0x3C with stop bit 0 -> stop_err pulse, no valid. Then send 0x5A -> valid with rx_data=0x5A.
4. P=16; drive rx_in low for 4 clocks then high -> busy rises then falls with no valid/err pulses. A following 0x81 is received correctly.
5. P=8; invert rx_in for 1 clock at edge_cnt=4 of data bit 2 in 0xF0 -> majority recovers, rx_data=0xF0 valid.
6. P=8, stop2=1; send 0x11 and 0x22 back-to-back, changing prescale to 16 mid-frame -> both received at P=8. Then assert rst mid-third frame -> all outputs 0, no pulses, state IDLE.
